mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

Memory-request initiator for the PDP-8 core: sits between the instruction execution logic and `memory_controller`, driving its address, data, enable and read-type inputs. Performs instruction fetch and memory-reference-instruction operand access. This includes effective-address formation (page zero / current page), indirect pointer reads, auto-index pointer pre-increment with write-back at 0010–0017 octal, and ISZ read-modify-write. One memory transaction is issued per clock; results and status are returned to the core with a done pulse.

## Interface
Parameters: none. `word` is the 12-bit type from `memory_utils`.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  request strobe, sampled only in IDLE
- op  in  2  00 FETCH, 01 READ, 10 WRITE, 11 ISZ
- pc  in  word  address of current instruction (fetch address; page source)
- ir  in  word  instruction word (ignored for FETCH)
- wr_data  in  word  store data for WRITE
- mem_read_data  in  word  from memory_controller read_data
- mem_address  out  word  to memory_controller address
- mem_write_data  out  word  to memory_controller write_data
- mem_read_enable  out  1  read strobe
- mem_read_type  out  1  READ_DATA / INSTRUCTION_FETCH (memory_utils encodings)
- mem_write_enable  out  1  write strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- result  out  word  fetched instruction or read operand (pre-increment value for ISZ)
- eff_addr  out  word  final effective address (pc for FETCH)
- skip  out  1  ISZ incremented value == 0

## Operation
- States: IDLE, FETCH, IND_READ, AUTO_WRITE, OP_READ, OP_WRITE, ISZ_WRITE, DONE.
- IDLE: enables low; on start latch op, pc, ir, wr_data; clear skip.
  - FETCH → FETCH.
  - Otherwise form direct address D = ir[7] ? {pc[11:7], ir[6:0]} : {5'b0, ir[6:0]}.
  - ir[8] (I bit) = 1 → IND_READ; else eff_addr := D → operand state.
- FETCH: read pc, type INSTRUCTION_FETCH; capture result; → DONE.
- IND_READ: read D, type READ_DATA; capture pointer P.
  - If 12'o0010 ≤ D ≤ 12'o0017: P := P+1 mod 4096 → AUTO_WRITE.
  - Else eff_addr := P → operand state.
- AUTO_WRITE: write P to D; eff_addr := P; → operand state.
- Operand state by op: READ → OP_READ; WRITE → OP_WRITE; ISZ → OP_READ.
- OP_READ: read eff_addr, type READ_DATA; capture result.
  - READ → DONE; ISZ → ISZ_WRITE.
- OP_WRITE: write wr_data to eff_addr; → DONE.
- ISZ_WRITE: write (result+1) mod 4096 to eff_addr; skip := (result+1 == 0); → DONE.
- DONE: done=1, enables low; → IDLE.
- Arithmetic: all 12-bit, wrap 7777 → 0000, no carry output.
- mem_read_enable and mem_write_enable never high together. mem_write_data = 0 when not writing. mem_address = 0 and mem_read_type = READ_DATA when idle.

## Timing
- Moore outputs decoded from registered state and latched fields; no combinational path from start to memory outputs.
- mem_read_data sampled at the rising edge ending the cycle in which mem_read_enable is high (single-cycle memory).
- Cycles from start-accept edge to done high:
  - FETCH / direct READ / direct WRITE: 2
  - indirect: 3
  - auto-index: 4
  - direct ISZ: 3; indirect ISZ: 4; auto-index ISZ: 5
- done high exactly one cycle; busy falls with the DONE→IDLE edge. A start asserted in the same cycle as done is ignored.
- start while busy: ignored, no queuing.
- result, eff_addr, skip hold until the next accepted start.
- Reset values: all outputs 0, state IDLE. Reset mid-transaction drops enables asynchronously; writes already clocked stand, none are completed or retried. reset with start: reset wins.

## Test plan
- FETCH, pc=0o0200, mem[0200]=0o1234 → one read at 0200 with INSTRUCTION_FETCH; done 2nd cycle; result=0o1234.
- READ, pc=0o0523, ir=0o1234, mem[0434]=0o0777 → single READ_DATA at 0o0434; eff_addr=0o0434; result=0o0777.
- READ, ir=0o1420, mem[0020]=0o3000, mem[3000]=0o0055 → reads 0020 then 3000; no write; result=0o0055; done 3rd cycle.
- READ, ir=0o1410, mem[0010]=0o7777 → read 0010; write 0o0000 to 0010; read 0000; eff_addr=0o0000; done 4th cycle.
- ISZ, ir=0o2050, mem[0050]=0o7777 → read 0050; write 0o0000 to 0050; skip=1. Repeat with 0o0005 → writes 0o0006, skip=0.
- Reset asserted during AUTO_WRITE → enables, busy, done low immediately; after release, a FETCH completes normally.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Purpose : PDP-8 memory-request initiator. Fetches instructions and does MRI operand
//           access: page-zero/current-page EA, indirect, auto-index write-back, ISZ RMW.
// Latency : 2 cycles from start-accept edge to done (direct), +1 indirect, +1 auto-index, +1 ISZ.
// Backpressure: none; start is honoured only in IDLE, and a start while busy or during done is dropped.
// Ports   : clk/reset (async, active-high); start/op/pc/ir/wr_data request in; mem_* drive
//           memory_controller (single-cycle read data); busy/done/result/eff_addr/skip back to core.

package memory_utils;
  typedef logic [11:0] word;
  localparam logic READ_DATA         = 1'b0;
  localparam logic INSTRUCTION_FETCH = 1'b1;
endpackage

module mem_access_sequencer
  import memory_utils::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  word        pc,
  input  word        ir,
  input  word        wr_data,
  input  word        mem_read_data,
  output word        mem_address,
  output word        mem_write_data,
  output logic       mem_read_enable,
  output logic       mem_read_type,
  output logic       mem_write_enable,
  output logic       busy,
  output logic       done,
  output word        result,
  output word        eff_addr,
  output logic       skip
);

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_ISZ   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_IND_READ, S_AUTO_WRITE,
    S_OP_READ, S_OP_WRITE, S_ISZ_WRITE, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  word        dir_addr_q, dir_addr_d;   // direct address D, source of the pointer read
  word        wr_data_q, wr_data_d;
  word        ptr_q, ptr_d;             // incremented auto-index pointer
  word        eff_addr_q, eff_addr_d;   // also holds pc during FETCH
  word        result_q, result_d;
  logic       skip_q, skip_d;

  word        direct_addr;
  word        isz_val;

  // Page-zero or current-page address from the offset in ir[6:0].
  assign direct_addr = ir[7] ? {pc[11:7], ir[6:0]} : {5'b0, ir[6:0]};
  assign isz_val     = result_q + 12'd1;

  function automatic state_t operand_state(input logic [1:0] o);
    return (o == OP_WRITE) ? S_OP_WRITE : S_OP_READ;
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dir_addr_d = dir_addr_q;
    wr_data_d  = wr_data_q;
    ptr_d      = ptr_q;
    eff_addr_d = eff_addr_q;
    result_d   = result_q;
    skip_d     = skip_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          wr_data_d = wr_data;
          skip_d    = 1'b0;
          if (op == OP_FETCH) begin
            eff_addr_d = pc;
            state_d    = S_FETCH;
          end else begin
            dir_addr_d = direct_addr;
            if (ir[8]) begin
              state_d = S_IND_READ;
            end else begin
              eff_addr_d = direct_addr;
              state_d    = operand_state(op);
            end
          end
        end
      end
      S_FETCH: begin
        result_d = mem_read_data;
        state_d  = S_DONE;
      end
      S_IND_READ: begin
        // Pointers at 0010-0017 are pre-incremented and written back before use.
        if (dir_addr_q inside {[12'o0010:12'o0017]}) begin
          ptr_d   = mem_read_data + 12'd1;
          state_d = S_AUTO_WRITE;
        end else begin
          eff_addr_d = mem_read_data;
          state_d    = operand_state(op_q);
        end
      end
      S_AUTO_WRITE: begin
        eff_addr_d = ptr_q;
        state_d    = operand_state(op_q);
      end
      S_OP_READ: begin
        result_d = mem_read_data;
        state_d  = (op_q == OP_ISZ) ? S_ISZ_WRITE : S_DONE;
      end
      S_OP_WRITE: state_d = S_DONE;
      S_ISZ_WRITE: begin
        skip_d  = (isz_val == 12'd0);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      dir_addr_q <= '0;
      wr_data_q  <= '0;
      ptr_q      <= '0;
      eff_addr_q <= '0;
      result_q   <= '0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dir_addr_q <= dir_addr_d;
      wr_data_q  <= wr_data_d;
      ptr_q      <= ptr_d;
      eff_addr_q <= eff_addr_d;
      result_q   <= result_d;
      skip_q     <= skip_d;
    end
  end

  // Moore decode: memory strobes depend only on the state flop, so reset drops them at once.
  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_read_enable  = 1'b0;
    mem_read_type    = READ_DATA;
    mem_write_enable = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_address     = eff_addr_q;
        mem_read_enable = 1'b1;
        mem_read_type   = INSTRUCTION_FETCH;
      end
      S_IND_READ: begin
        mem_address     = dir_addr_q;
        mem_read_enable = 1'b1;
      end
      S_AUTO_WRITE: begin
        mem_address      = dir_addr_q;
        mem_write_data   = ptr_q;
        mem_write_enable = 1'b1;
      end
      S_OP_READ: begin
        mem_address     = eff_addr_q;
        mem_read_enable = 1'b1;
      end
      S_OP_WRITE: begin
        mem_address      = eff_addr_q;
        mem_write_data   = wr_data_q;
        mem_write_enable = 1'b1;
      end
      S_ISZ_WRITE: begin
        mem_address      = eff_addr_q;
        mem_write_data   = isz_val;
        mem_write_enable = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign eff_addr = eff_addr_q;
  assign skip     = skip_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Purpose : self-checking bench for mem_access_sequencer against a transaction-list model.
// Latency : model predicts one bus entry per cycle after start-accept, last entry is done.
// Backpressure: random start/op noise is driven while busy and must be ignored.

module tb_mem_access_sequencer;
  import memory_utils::*;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] op;
  word        pc, ir, wr_data, mem_read_data, mem_address, mem_write_data, result, eff_addr;
  logic       mem_read_enable, mem_read_type, mem_write_enable, busy, done, skip;

  always #5 clk = ~clk;

  mem_access_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .pc(pc), .ir(ir),
    .wr_data(wr_data), .mem_read_data(mem_read_data), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_enable(mem_read_enable),
    .mem_read_type(mem_read_type), .mem_write_enable(mem_write_enable),
    .busy(busy), .done(done), .result(result), .eff_addr(eff_addr), .skip(skip)
  );

  // One expected bus cycle: read/write strobes, fetch type, address, write data, done.
  typedef struct {
    bit  re;
    bit  we;
    bit  ft;
    word addr;
    word wd;
    bit  dn;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  word  mem[4096];
  word  ref_mem[4096];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  word  exp_res = '0;
  word  exp_ea  = '0;
  bit   exp_skip = 1'b0;
  bit   fill_en = 1'b0;
  bit   poke_en = 1'b0;
  word  poke_a = '0;
  word  poke_d = '0;

  function automatic word fill_word(input int i);
    return 12'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // Single-cycle memory: combinational read, write on the clock edge.
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 4096; i++) mem[i] <= fill_word(i);
    end else if (poke_en) begin
      mem[poke_a] <= poke_d;
    end else if (mem_write_enable) begin
      mem[mem_address] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input bit re, input bit we, input bit ft,
                               input word a, input word wd, input bit dn);
    exp_q.push_back('{re, we, ft, a, wd, dn});
  endfunction

  // Reference: list the memory transactions the instruction must perform, in order.
  task automatic model(input logic [1:0] o, input word p, input word i, input word w);
    word d, ea, v;
    exp_skip = 1'b0;
    if (o == 2'b00) begin
      push(1, 0, 1, p, 0, 0);
      exp_res = ref_mem[p];
      ea = p;
    end else begin
      d  = (i[7] ? (p & 12'o7600) : 12'o0000) | (i & 12'o0177);
      ea = d;
      if (i[8]) begin
        push(1, 0, 0, d, 0, 0);
        ea = ref_mem[d];
        if (d >= 12'o0010 && d <= 12'o0017) begin
          ea = ea + 12'd1;
          push(0, 1, 0, d, ea, 0);
          ref_mem[d] = ea;
        end
      end
      case (o)
        2'b01: begin
          push(1, 0, 0, ea, 0, 0);
          exp_res = ref_mem[ea];
        end
        2'b10: begin
          push(0, 1, 0, ea, w, 0);
          ref_mem[ea] = w;
        end
        default: begin
          push(1, 0, 0, ea, 0, 0);
          exp_res = ref_mem[ea];
          v = exp_res + 12'd1;
          push(0, 1, 0, ea, v, 0);
          ref_mem[ea] = v;
          exp_skip = (v == 12'd0);
        end
      endcase
    end
    exp_ea = ea;
    push(0, 0, 0, 0, 0, 1);
  endtask

  // Compare process: every cycle, either the next expected bus entry or the idle state.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("rd_en", mem_read_enable, cur.re);
        chk("wr_en", mem_write_enable, cur.we);
        chk("rd_type", mem_read_type, cur.ft);
        chk("addr", mem_address, cur.addr);
        chk("wdata", mem_write_data, cur.wd);
        chk("busy", busy, 1);
        chk("done", done, cur.dn);
        if (cur.dn) begin
          chk("result", result, exp_res);
          chk("eff_addr", eff_addr, exp_ea);
          chk("skip", skip, exp_skip);
        end
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_en", {mem_read_enable, mem_write_enable, mem_read_type}, 0);
        chk("idle_addr", mem_address, 0);
        chk("idle_wdata", mem_write_data, 0);
      end
    end
  end

  task automatic poke(input word a, input word d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic run_op(input logic [1:0] o, input word p, input word i, input word w,
                        output int len);
    @(negedge clk);
    start = 1'b1; op = o; pc = p; ir = i; wr_data = w;
    @(posedge clk); #1;
    start = 1'b0;
    model(o, p, i, w);
    len = exp_q.size();
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      pc = 12'($urandom); ir = 12'($urandom); wr_data = 12'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int len;
    logic [1:0] ro;
    word rp, ri;
    reset = 1'b1; start = 1'b0; op = '0; pc = '0; ir = '0; wr_data = '0;
    fill_en = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = fill_word(i);
    repeat (2) @(posedge clk);
    #1 fill_en = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", {mem_read_enable, mem_write_enable, mem_read_type}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_regs", {result, eff_addr, skip}, 0);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Directed cases with hand-computed outcomes.
    poke(12'o0200, 12'o1234);
    run_op(2'b00, 12'o0200, 12'o0000, 12'o0000, len);
    chk("fetch_len", len, 2);
    chk("fetch_res", result, 12'o1234);
    chk("fetch_ea", eff_addr, 12'o0200);

    poke(12'o0434, 12'o0777);
    run_op(2'b01, 12'o0523, 12'o1234, 12'o0000, len);
    chk("cur_page_len", len, 2);
    chk("cur_page_ea", eff_addr, 12'o0434);
    chk("cur_page_res", result, 12'o0777);

    poke(12'o0020, 12'o3000);
    poke(12'o3000, 12'o0055);
    run_op(2'b01, 12'o0000, 12'o1420, 12'o0000, len);
    chk("ind_len", len, 3);
    chk("ind_res", result, 12'o0055);

    poke(12'o0010, 12'o7777);
    poke(12'o0000, 12'o4321);
    run_op(2'b01, 12'o0000, 12'o1410, 12'o0000, len);
    chk("auto_len", len, 4);
    chk("auto_ea", eff_addr, 12'o0000);
    chk("auto_res", result, 12'o4321);
    chk("auto_wb", mem[12'o0010], 12'o0000);

    poke(12'o0050, 12'o7777);
    run_op(2'b11, 12'o0000, 12'o2050, 12'o0000, len);
    chk("isz_len", len, 3);
    chk("isz_skip1", skip, 1);
    chk("isz_wrap", mem[12'o0050], 12'o0000);
    poke(12'o0050, 12'o0005);
    run_op(2'b11, 12'o0000, 12'o2050, 12'o0000, len);
    chk("isz_skip0", skip, 0);
    chk("isz_inc", mem[12'o0050], 12'o0006);
    chk("isz_res", result, 12'o0005);

    poke(12'o0011, 12'o0100);
    poke(12'o0101, 12'o7777);
    run_op(2'b11, 12'o0000, 12'o2411, 12'o0000, len);
    chk("auto_isz_len", len, 5);
    chk("auto_isz_skip", skip, 1);
    chk("auto_isz_ptr", mem[12'o0011], 12'o0101);

    run_op(2'b10, 12'o4567, 12'o0252, 12'o1357, len);
    chk("write_len", len, 2);
    chk("write_ea", eff_addr, 12'o4452);
    chk("write_mem", mem[12'o4452], 12'o1357);

    // Randomized instructions, biased so auto-index pointers show up often.
    repeat (250) begin
      ro = 2'($urandom_range(0, 3));
      rp = 12'($urandom);
      ri = 12'($urandom);
      if ($urandom_range(0, 3) == 0) ri = {3'($urandom), 2'b10, 4'b0001, 3'($urandom)};
      run_op(ro, rp, ri, 12'($urandom), len);
    end

    // Reset in the middle of the auto-index write-back.
    chk_en = 1'b0;
    poke(12'o0012, 12'o0400);
    @(negedge clk);
    start = 1'b1; op = 2'b01; pc = 12'o0000; ir = 12'o0412; wr_data = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("pre_rst_rd", {mem_read_enable, mem_address}, {1'b1, 12'o0012});
    @(posedge clk); #1;
    chk("pre_rst_wr", {mem_write_enable, mem_write_data}, {1'b1, 12'o0401});
    reset = 1'b1;
    #1;
    chk("mid_rst_en", {mem_read_enable, mem_write_enable}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", mem_address, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_nowb", mem[12'o0012], 12'o0400);
    chk("mid_rst_res", result, 0);
    exp_res = '0; exp_ea = '0; exp_skip = 1'b0;
    chk_en = 1'b1;
    poke(12'o0300, 12'o5252);
    run_op(2'b00, 12'o0300, 12'o0000, 12'o0000, len);
    chk("post_rst_len", len, 2);
    chk("post_rst_res", result, 12'o5252);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
